// File: rtl/vec_store_stage.sv
// vec_store_stage: SIMT writeback/store stage with divergence stack; STORE_STAGE_PERF_EN adds perf counters
module vec_store_stage #(
  parameter int NUM_LANES = 8,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int REG_ID_W  = 5,
  parameter int DIV_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_opcode,
  input  logic [NUM_LANES-1:0]        in_mask,
  input  logic [NUM_LANES-1:0]        in_mask_false,
  input  logic [REG_ID_W-1:0]         in_dest_reg,
  input  logic [ADDR_W-1:0]           in_dest_addr,
  input  logic [ADDR_W-1:0]           in_src_addr,
  input  logic [NUM_LANES*DATA_W-1:0] in_src_value,
  input  logic [NUM_LANES*DATA_W-1:0] in_dest_value,
  input  logic                        in_store_to_pc,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_write,
  output logic [NUM_LANES-1:0]        mem_req_mask,
  output logic [NUM_LANES*DATA_W-1:0] mem_req_addr,
  output logic [NUM_LANES*DATA_W-1:0] mem_req_wdata,
  input  logic                        mem_rsp_valid,
  input  logic [NUM_LANES*DATA_W-1:0] mem_rsp_data,
  output logic                        rf_we,
  output logic [NUM_LANES-1:0]        rf_lane_mask,
  output logic [REG_ID_W-1:0]         rf_waddr,
  output logic [NUM_LANES*DATA_W-1:0] rf_wdata,
  output logic                        fetch_valid,
  input  logic                        fetch_ready,
  output logic [ADDR_W-1:0]           fetch_pc,
  output logic [NUM_LANES-1:0]        fetch_mask,
  output logic                        halted,
  output logic                        err_div_overflow,
  output logic                        err_illegal
`ifdef STORE_STAGE_PERF_EN
  ,
  output logic [31:0]                 perf_divergences,
  output logic [31:0]                 perf_mem_wait_cycles
`endif
);
  localparam int LW = NUM_LANES * DATA_W;
  localparam int IDX_W = $clog2(DIV_DEPTH);
  localparam int SP_W = IDX_W + 1;
  localparam logic [2:0] OP_HALT = 3'd1, OP_CJMP = 3'd2, OP_JMP = 3'd3, OP_LOAD = 3'd4,
                         OP_STORE = 3'd5, OP_SETREG = 3'd6, OP_ILL = 3'd7;

  typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, FETCH, HALTED} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0]    stk_pc   [DIV_DEPTH];
  logic [NUM_LANES-1:0] stk_mask [DIV_DEPTH];
  logic [SP_W-1:0]      sp, sp_nx;
  logic [IDX_W-1:0]     top;
  logic                 push, full, take_false;

  logic                 in_ready_nx, mem_req_valid_nx, mem_req_write_nx, rf_we_nx, fetch_valid_nx;
  logic                 halted_nx, err_div_overflow_nx, err_illegal_nx, lat_to_pc, lat_to_pc_nx;
  logic [NUM_LANES-1:0] mem_req_mask_nx, rf_lane_mask_nx, fetch_mask_nx, lat_mask, lat_mask_nx;
  logic [LW-1:0]        mem_req_addr_nx, mem_req_wdata_nx, rf_wdata_nx;
  logic [REG_ID_W-1:0]  rf_waddr_nx, lat_reg, lat_reg_nx;
  logic [ADDR_W-1:0]    fetch_pc_nx;

  assign full = sp == SP_W'(DIV_DEPTH);
  assign top = IDX_W'(sp - SP_W'(1));
  assign take_false = in_mask == '0 || in_mask_false != '0;

  always_comb begin
    state_nx = state;
    sp_nx = sp;
    push = 1'b0;
    mem_req_valid_nx = mem_req_valid;
    mem_req_write_nx = mem_req_write;
    mem_req_mask_nx = mem_req_mask;
    mem_req_addr_nx = mem_req_addr;
    mem_req_wdata_nx = mem_req_wdata;
    rf_we_nx = 1'b0;
    rf_lane_mask_nx = rf_lane_mask;
    rf_waddr_nx = rf_waddr;
    rf_wdata_nx = rf_wdata;
    fetch_valid_nx = fetch_valid;
    fetch_pc_nx = fetch_pc;
    fetch_mask_nx = fetch_mask;
    halted_nx = halted;
    err_div_overflow_nx = err_div_overflow;
    err_illegal_nx = err_illegal;
    lat_mask_nx = lat_mask;
    lat_reg_nx = lat_reg;
    lat_to_pc_nx = lat_to_pc;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        case (in_opcode)
          OP_HALT: if (sp == '0) begin
            state_nx = HALTED;
            halted_nx = 1'b1;
          end else begin
            sp_nx = sp - SP_W'(1);
            state_nx = FETCH;
            fetch_valid_nx = 1'b1;
            fetch_pc_nx = stk_pc[top];
            fetch_mask_nx = stk_mask[top];
          end
          OP_CJMP: begin
            state_nx = FETCH;
            fetch_valid_nx = 1'b1;
            fetch_pc_nx = take_false ? in_src_addr : in_dest_addr;
            fetch_mask_nx = take_false ? in_mask_false : in_mask;
            // only a genuine split needs the true path remembered
            if (in_mask != '0 && in_mask_false != '0) begin
              if (full) err_div_overflow_nx = 1'b1;
              else begin
                push = 1'b1;
                sp_nx = sp + SP_W'(1);
              end
            end
          end
          OP_JMP: begin
            state_nx = FETCH;
            fetch_valid_nx = 1'b1;
            fetch_pc_nx = in_dest_addr;
            fetch_mask_nx = in_mask;
          end
          OP_LOAD, OP_STORE: begin
            state_nx = MEM_REQ;
            mem_req_valid_nx = 1'b1;
            mem_req_write_nx = in_opcode == OP_STORE;
            mem_req_mask_nx = in_mask;
            mem_req_addr_nx = in_opcode == OP_STORE ? in_dest_value : in_src_value;
            mem_req_wdata_nx = in_opcode == OP_STORE ? in_src_value : mem_req_wdata;
            lat_mask_nx = in_mask;
            lat_reg_nx = in_dest_reg;
            lat_to_pc_nx = in_store_to_pc;
          end
          OP_SETREG: begin
            rf_we_nx = 1'b1;
            rf_lane_mask_nx = in_mask;
            rf_waddr_nx = in_dest_reg;
            rf_wdata_nx = in_src_value;
          end
          OP_ILL: err_illegal_nx = 1'b1;
          default: ;
        endcase
      end
      MEM_REQ: if (mem_req_ready) begin
        mem_req_valid_nx = 1'b0;
        state_nx = mem_req_write ? IDLE : MEM_WAIT;
      end
      MEM_WAIT: if (mem_rsp_valid) begin
        rf_we_nx = 1'b1;
        rf_lane_mask_nx = lat_mask;
        rf_waddr_nx = lat_reg;
        rf_wdata_nx = mem_rsp_data;
        state_nx = lat_to_pc ? FETCH : IDLE;
        fetch_valid_nx = lat_to_pc;
        fetch_pc_nx = lat_to_pc ? mem_rsp_data[ADDR_W-1:0] : fetch_pc;
        fetch_mask_nx = lat_to_pc ? lat_mask : fetch_mask;
      end
      FETCH: if (fetch_ready) begin
        fetch_valid_nx = 1'b0;
        state_nx = IDLE;
      end
      default: ;
    endcase
    in_ready_nx = state_nx == IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sp <= '0;
      in_ready <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_mask <= '0;
      mem_req_addr <= '0;
      mem_req_wdata <= '0;
      rf_we <= 1'b0;
      rf_lane_mask <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      fetch_valid <= 1'b0;
      fetch_pc <= '0;
      fetch_mask <= '0;
      halted <= 1'b0;
      err_div_overflow <= 1'b0;
      err_illegal <= 1'b0;
      lat_mask <= '0;
      lat_reg <= '0;
      lat_to_pc <= 1'b0;
    end else begin
      state <= state_nx;
      sp <= sp_nx;
      in_ready <= in_ready_nx;
      mem_req_valid <= mem_req_valid_nx;
      mem_req_write <= mem_req_write_nx;
      mem_req_mask <= mem_req_mask_nx;
      mem_req_addr <= mem_req_addr_nx;
      mem_req_wdata <= mem_req_wdata_nx;
      rf_we <= rf_we_nx;
      rf_lane_mask <= rf_lane_mask_nx;
      rf_waddr <= rf_waddr_nx;
      rf_wdata <= rf_wdata_nx;
      fetch_valid <= fetch_valid_nx;
      fetch_pc <= fetch_pc_nx;
      fetch_mask <= fetch_mask_nx;
      halted <= halted_nx;
      err_div_overflow <= err_div_overflow_nx;
      err_illegal <= err_illegal_nx;
      lat_mask <= lat_mask_nx;
      lat_reg <= lat_reg_nx;
      lat_to_pc <= lat_to_pc_nx;
    end
  end

  // stack contents need no reset: the pointer alone defines validity
  always_ff @(posedge clk) begin
    if (push) begin
      stk_pc[sp[IDX_W-1:0]] <= in_dest_addr;
      stk_mask[sp[IDX_W-1:0]] <= in_mask;
    end
  end

`ifdef STORE_STAGE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_divergences <= '0;
      perf_mem_wait_cycles <= '0;
    end else begin
      if (push && !(&perf_divergences)) perf_divergences <= perf_divergences + 32'd1;
      if (state == MEM_WAIT && !(&perf_mem_wait_cycles)) perf_mem_wait_cycles <= perf_mem_wait_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vec_store_stage.sv
// tb_vec_store_stage: randomized scoreboard bench for vec_store_stage
module tb_vec_store_stage;
  localparam int NL = 8, DW = 64, AW = 32, RW = 5, DD = 4, LW = NL * DW;

  typedef struct {logic [NL-1:0] mask; logic [RW-1:0] rg; logic [LW-1:0] data;} rf_t;
  typedef struct {logic wr; logic [NL-1:0] mask; logic [LW-1:0] addr; logic [LW-1:0] wdata;} mem_t;
  typedef struct {logic [AW-1:0] pc; logic [NL-1:0] mask;} fe_t;
  typedef struct {logic [RW-1:0] rg; logic [NL-1:0] mask; logic to_pc;} ld_t;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [2:0] in_opcode = '0;
  logic [NL-1:0] in_mask = '0, in_mask_false = '0;
  logic [RW-1:0] in_dest_reg = '0;
  logic [AW-1:0] in_dest_addr = '0, in_src_addr = '0;
  logic [LW-1:0] in_src_value = '0, in_dest_value = '0;
  logic in_store_to_pc = 1'b0;
  logic mem_req_valid, mem_req_ready = 1'b0, mem_req_write;
  logic [NL-1:0] mem_req_mask;
  logic [LW-1:0] mem_req_addr, mem_req_wdata;
  logic mem_rsp_valid = 1'b0;
  logic [LW-1:0] mem_rsp_data = '0;
  logic rf_we;
  logic [NL-1:0] rf_lane_mask;
  logic [RW-1:0] rf_waddr;
  logic [LW-1:0] rf_wdata;
  logic fetch_valid, fetch_ready = 1'b0;
  logic [AW-1:0] fetch_pc;
  logic [NL-1:0] fetch_mask;
  logic halted, err_div_overflow, err_illegal;
`ifdef STORE_STAGE_PERF_EN
  logic [31:0] perf_div, perf_mw;
`endif

  vec_store_stage #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW), .REG_ID_W(RW), .DIV_DEPTH(DD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_mask(in_mask), .in_mask_false(in_mask_false), .in_dest_reg(in_dest_reg),
    .in_dest_addr(in_dest_addr), .in_src_addr(in_src_addr), .in_src_value(in_src_value),
    .in_dest_value(in_dest_value), .in_store_to_pc(in_store_to_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_mask(mem_req_mask), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_we(rf_we), .rf_lane_mask(rf_lane_mask), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc), .fetch_mask(fetch_mask),
    .halted(halted), .err_div_overflow(err_div_overflow), .err_illegal(err_illegal)
`ifdef STORE_STAGE_PERF_EN
    , .perf_divergences(perf_div), .perf_mem_wait_cycles(perf_mw)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  rf_t exp_rf[$];
  mem_t exp_mem[$];
  fe_t exp_fetch[$];
  ld_t pend[$];
  fe_t mstk[$];
  bit exp_ovf = 0, exp_ill = 0, exp_halt = 0;
  bit rsp_en = 1, use_ovr = 0, rsp_busy = 0;
  logic [LW-1:0] ovr_data = '0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    failures++;
    $display("FAIL %s unexpected act=1 exp=0", nm);
  endtask

  function automatic logic [LW-1:0] rnd_vec();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NL-1:0] rnd_mask();
    return ($urandom_range(0, 3) == 0) ? '0 : NL'($urandom);
  endfunction

  function automatic fe_t mk_fe(input logic [AW-1:0] p, input logic [NL-1:0] k);
    fe_t f;
    f.pc = p;
    f.mask = k;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: compares every presented output against the head of its queue
  initial begin
    rf_t r;
    mem_t m;
    fe_t f;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rf_we) begin
          if (exp_rf.size() == 0) unexp("rf_we");
          else begin
            r = exp_rf.pop_front();
            chk("rf_lane_mask", rf_lane_mask, r.mask);
            chk("rf_waddr", rf_waddr, r.rg);
            chk("rf_wdata", rf_wdata, r.data);
          end
        end
        if (mem_req_valid) begin
          if (exp_mem.size() == 0) unexp("mem_req_valid");
          else begin
            m = exp_mem[0];
            chk("mem_req_write", mem_req_write, m.wr);
            chk("mem_req_mask", mem_req_mask, m.mask);
            chk("mem_req_addr", mem_req_addr, m.addr);
            if (m.wr) chk("mem_req_wdata", mem_req_wdata, m.wdata);
            if (mem_req_ready) void'(exp_mem.pop_front());
          end
        end
        if (fetch_valid) begin
          if (exp_fetch.size() == 0) unexp("fetch_valid");
          else begin
            f = exp_fetch[0];
            chk("fetch_pc", fetch_pc, f.pc);
            chk("fetch_mask", fetch_mask, f.mask);
            if (fetch_ready) void'(exp_fetch.pop_front());
          end
        end
      end
    end
  end

  // memory responder: answers each accepted load after a random delay
  initial begin
    ld_t l;
    rf_t r;
    logic [LW-1:0] d;
    forever begin
      @(negedge clk);
      if (!reset && mem_req_valid && mem_req_ready && !mem_req_write && pend.size() > 0) begin
        l = pend.pop_front();
        if (rsp_en) begin
          rsp_busy = 1;
          repeat ($urandom_range(1, 5)) @(posedge clk);
          #1;
          d = use_ovr ? ovr_data : rnd_vec();
          mem_rsp_data = d;
          mem_rsp_valid = 1'b1;
          r.mask = l.mask;
          r.rg = l.rg;
          r.data = d;
          exp_rf.push_back(r);
          if (l.to_pc) exp_fetch.push_back(mk_fe(d[AW-1:0], l.mask));
          tick();
          mem_rsp_valid = 1'b0;
          rsp_busy = 0;
        end
      end
    end
  end

  initial forever begin
    tick();
    mem_req_ready = $urandom_range(0, 2) == 0;
    fetch_ready = $urandom_range(0, 1) == 0;
  end

  initial begin
    #800000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [2:0] op, input logic [NL-1:0] m, input logic [NL-1:0] mf,
                      input logic [RW-1:0] rg, input logic [AW-1:0] da, input logic [AW-1:0] sa,
                      input logic [LW-1:0] sv, input logic [LW-1:0] dv, input logic tp);
    int n = 0;
    mem_t me;
    rf_t r;
    ld_t l;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    if (!in_ready) return;
    in_opcode = op; in_mask = m; in_mask_false = mf; in_dest_reg = rg;
    in_dest_addr = da; in_src_addr = sa; in_src_value = sv; in_dest_value = dv;
    in_store_to_pc = tp; in_valid = 1'b1;
    case (op)
      3'd1: if (mstk.size() == 0) exp_halt = 1; else exp_fetch.push_back(mstk.pop_back());
      3'd2: if (m == '0) exp_fetch.push_back(mk_fe(sa, mf));
            else if (mf == '0) exp_fetch.push_back(mk_fe(da, m));
            else begin
              if (mstk.size() == DD) exp_ovf = 1; else mstk.push_back(mk_fe(da, m));
              exp_fetch.push_back(mk_fe(sa, mf));
            end
      3'd3: exp_fetch.push_back(mk_fe(da, m));
      3'd4, 3'd5: begin
        me.wr = op == 3'd5; me.mask = m; me.addr = me.wr ? dv : sv; me.wdata = sv;
        exp_mem.push_back(me);
        if (!me.wr) begin
          l.rg = rg; l.mask = m; l.to_pc = tp;
          pend.push_back(l);
        end
      end
      3'd6: begin
        r.mask = m; r.rg = rg; r.data = sv;
        exp_rf.push_back(r);
      end
      3'd7: exp_ill = 1;
      default: ;
    endcase
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    exp_rf.delete(); exp_mem.delete(); exp_fetch.delete(); pend.delete(); mstk.delete();
    exp_ovf = 0; exp_ill = 0; exp_halt = 0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_req_write"}, mem_req_write, 0);
    chk({tag, "_mem_req_mask"}, mem_req_mask, 0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 0);
    chk({tag, "_mem_req_wdata"}, mem_req_wdata, 0);
    chk({tag, "_rf_we"}, rf_we, 0);
    chk({tag, "_rf_lane_mask"}, rf_lane_mask, 0);
    chk({tag, "_rf_waddr"}, rf_waddr, 0);
    chk({tag, "_rf_wdata"}, rf_wdata, 0);
    chk({tag, "_fetch_valid"}, fetch_valid, 0);
    chk({tag, "_fetch_pc"}, fetch_pc, 0);
    chk({tag, "_fetch_mask"}, fetch_mask, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_err_div_overflow"}, err_div_overflow, 0);
    chk({tag, "_err_illegal"}, err_illegal, 0);
  endtask

  task automatic chk_flags();
    chk("err_div_overflow", err_div_overflow, exp_ovf);
    chk("err_illegal", err_illegal, exp_ill);
    chk("halted", halted, exp_halt);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_rf.size() + exp_mem.size() + exp_fetch.size() + pend.size() + int'(rsp_busy)) != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_rf.size() + exp_mem.size() + exp_fetch.size() + pend.size() + int'(rsp_busy), 0);
  endtask

  task automatic chk_halted();
    repeat (2) tick();
    chk("halt_halted", halted, 1);
    chk("halt_in_ready", in_ready, 0);
  endtask

  initial begin
    logic [LW-1:0] sv;
    logic [2:0] op;
    int r;
    do_reset();
    chk_idle_outputs("reset");

    for (int i = 0; i < NL; i++) sv[i*DW +: DW] = DW'(i + 1);
    send(3'd6, 8'h0F, 8'h00, 5'd3, '0, '0, sv, '0, 1'b0);
    chk("setreg_rf_we", rf_we, 1);
    chk("setreg_in_ready", in_ready, 1);
    wait_drain();

    use_ovr = 1;
    ovr_data = rnd_vec();
    ovr_data[DW-1:0] = 64'h1000;
    send(3'd4, 8'hA5, 8'h00, 5'd7, '0, '0, rnd_vec(), '0, 1'b1);
    chk("load_in_ready", in_ready, 0);
    wait_drain();
    use_ovr = 0;
    send(3'd5, 8'h3C, 8'h00, 5'd0, '0, '0, rnd_vec(), rnd_vec(), 1'b0);
    wait_drain();

    send(3'd2, 8'hF0, 8'h0F, 5'd0, 32'h40, 32'h80, '0, '0, 1'b0);
    send(3'd1, '0, '0, '0, '0, '0, '0, '0, 1'b0);
    send(3'd1, '0, '0, '0, '0, '0, '0, '0, 1'b0);
    chk_halted();
    wait_drain();

    do_reset();
    send(3'd2, 8'h00, 8'hFF, 5'd0, 32'h100, 32'h200, '0, '0, 1'b0);
    send(3'd1, '0, '0, '0, '0, '0, '0, '0, 1'b0);
    chk_halted();
    wait_drain();

    do_reset();
    for (int k = 0; k <= DD; k++) begin
      chk("ovf_flag_before", err_div_overflow, 0);
      send(3'd2, 8'(k + 1), ~8'(k + 1), 5'd0, 32'h1000 + 32'(k * 4), 32'h2000 + 32'(k * 4), '0, '0, 1'b0);
    end
    chk("ovf_flag_after", err_div_overflow, 1);
    for (int k = 0; k < DD; k++) send(3'd1, '0, '0, '0, '0, '0, '0, '0, 1'b0);
    send(3'd1, '0, '0, '0, '0, '0, '0, '0, 1'b0);
    chk_halted();
    chk_flags();
    wait_drain();

    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      op = r == 0 ? 3'd0 : r < 3 ? 3'd1 : (r < 6 || r == 15) ? 3'd2 : r < 8 ? 3'd3 :
           r < 10 ? 3'd4 : r < 12 ? 3'd5 : r < 14 ? 3'd6 : 3'd7;
      send(op, rnd_mask(), rnd_mask(), RW'($urandom), $urandom, $urandom, rnd_vec(), rnd_vec(),
           1'($urandom_range(0, 1)));
      chk_flags();
      if (exp_halt) begin
        chk_halted();
        wait_drain();
        do_reset();
      end
    end
    wait_drain();

    do_reset();
    rsp_en = 0;
    send(3'd4, 8'hFF, 8'h00, 5'd9, '0, '0, rnd_vec(), '0, 1'b0);
    for (int n = 0; n < 200 && exp_mem.size() != 0; n++) tick();
    repeat (2) tick();
    chk("memwait_in_ready", in_ready, 0);
    do_reset();
    mem_rsp_data = rnd_vec();
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("post_reset_rf_we", rf_we, 0);
    end
    chk_idle_outputs("midreset");
    rsp_en = 1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vec_store_stage.md
Name: vec_store_stage

Overview:
Parametrised writeback/store stage of the SIMT vector core. Sits after execute and before fetch. It retires execute packets by doing the following:
- writes lane-masked results to the register file;
- issues vector loads and stores to the memory bus;
- redirects fetch on jumps.
It manages an internal divergence stack for conditional jumps. Unlike the previous generation, it has configurable lane count, data width and stack depth, lane-masked register writes, degenerate-branch elision and overflow detection.

Parameters:
NUM_LANES, 8, vector threads per warp
DATA_W, 64, bits per lane value
ADDR_W, 32, PC/address width
REG_ID_W, 5, register index width
DIV_DEPTH, 4, divergence stack entries (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  execute packet valid
in_ready  out  1  stage can accept packet
in_opcode  in  3  0 NOP, 1 HALT, 2 CJMP, 3 JMP, 4 LOAD, 5 STORE, 6 SETREG, 7 illegal
in_mask  in  NUM_LANES  exec mask (CJMP: true-path mask)
in_mask_false  in  NUM_LANES  CJMP false-path mask
in_dest_reg  in  REG_ID_W  destination register
in_dest_addr  in  ADDR_W  JMP target / CJMP true target
in_src_addr  in  ADDR_W  CJMP false target
in_src_value  in  NUM_LANES*DATA_W  SETREG data / LOAD addresses / STORE data
in_dest_value  in  NUM_LANES*DATA_W  STORE addresses
in_store_to_pc  in  1  LOAD result also redirects fetch
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1 store, 0 load
mem_req_mask  out  NUM_LANES  active lanes
mem_req_addr  out  NUM_LANES*DATA_W  per-lane addresses
mem_req_wdata  out  NUM_LANES*DATA_W  store data
mem_rsp_valid  in  1  load response valid
mem_rsp_data  in  NUM_LANES*DATA_W  load data
rf_we  out  1  register write pulse
rf_lane_mask  out  NUM_LANES  lanes written
rf_waddr  out  REG_ID_W  register index
rf_wdata  out  NUM_LANES*DATA_W  write data
fetch_valid  out  1  fetch redirect valid
fetch_ready  in  1  fetch accepts redirect
fetch_pc  out  ADDR_W  new PC
fetch_mask  out  NUM_LANES  new exec mask
halted  out  1  core halted, sticky
err_div_overflow  out  1  sticky: push dropped on full stack
err_illegal  out  1  sticky: opcode 7 seen

Behaviour:
- Reset clears the following to 0: all outputs except in_ready, the FSM state (IDLE) and the stack pointer (empty). in_ready=1 after reset. A reset mid-transaction abandons it.
- All outputs are registered. A packet is accepted when in_valid&&in_ready. in_ready=1 only in IDLE.
- FSM states:
  - IDLE: accept packet, decode.
  - MEM_REQ: hold mem_req_* stable until mem_req_ready.
  - MEM_WAIT: wait for mem_rsp_valid.
  - FETCH: hold fetch_* stable until fetch_ready.
  - HALTED: terminal; in_ready=0; exit only by reset.
- NOP: no effect, stay in IDLE.
- Illegal opcode (7): set err_illegal, otherwise treated as NOP.
- SETREG: next cycle, one-cycle rf_we pulse. rf_lane_mask=in_mask, rf_waddr=in_dest_reg, rf_wdata=in_src_value. Stay in IDLE.
- STORE: go to MEM_REQ with write=1, addr=in_dest_value, wdata=in_src_value, mask=in_mask. Return to IDLE the cycle after handshake.
- LOAD: go to MEM_REQ with write=0, addr=in_src_value. After handshake go to MEM_WAIT.
  - On mem_rsp_valid: one-cycle rf_we with the response data and in_mask.
  - If in_store_to_pc, go to FETCH with pc = mem_rsp_data[ADDR_W-1:0] (lane 0) and mask=in_mask. Otherwise go to IDLE.
- mem_rsp_valid outside MEM_WAIT is ignored.
- JMP: go to FETCH with pc=in_dest_addr, mask=in_mask.
- CJMP (t=in_mask, f=in_mask_false):
  - t==0: FETCH(in_src_addr, f), no push.
  - f==0: FETCH(in_dest_addr, t), no push.
  - Both nonzero: push {in_dest_addr, t}, then FETCH(in_src_addr, f).
  - Stack full (DIV_DEPTH entries): set err_div_overflow, drop the push, still FETCH the false path.
- HALT:
  - Stack empty: go to HALTED, halted=1 next cycle.
  - Otherwise: pop the top entry (LIFO) and FETCH(popped pc, popped mask).
- A pop and a push never occur in the same cycle.

Optional Feature:
STORE_STAGE_PERF_EN: adds 32-bit saturating output counters perf_divergences (CJMP pushes) and perf_mem_wait_cycles (cycles in MEM_WAIT), both cleared by reset. Without the macro these ports do not exist and no counter logic is built.

Test Plan:
- SETREG, in_mask=8'h0F, reg 3, lanes=i+1 -> one cycle later rf_we=1, rf_lane_mask=8'h0F, rf_waddr=3, data echoed; in_ready stays 1.
- LOAD with in_store_to_pc=1, mem_req_ready delayed 3 cycles, response lane0=0x1000 after 5 cycles -> single mem request held stable, rf_we pulse, then fetch_pc=0x1000, fetch_mask=in_mask.
- CJMP t=8'hF0, f=8'h0F, dest=0x40, src=0x80 -> fetch(0x80, 0x0F). Then HALT -> fetch(0x40, 0xF0). Then HALT -> halted=1, in_ready=0.
- CJMP t=0, f=8'hFF -> fetch(src, 0xFF), stack unchanged; a following HALT halts.
- DIV_DEPTH+1 nondegenerate CJMPs -> err_div_overflow=1 on the last one. Fetch still issued. Draining with DIV_DEPTH HALTs yields LIFO order, then halt.
- Assert reset during MEM_WAIT, then pulse mem_rsp_valid -> state IDLE, no rf_we, outputs 0, in_ready=1.
